// File: rtl/wb_regfile.sv
// Writeback stage and 16-bit architectural register file with a one-entry
// writeback pipe register, read-port bypass from that register and zero/lt flags.
module wb_regfile #(
  parameter int NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_reg_we,
  input  logic [2:0]  ex_rd,
  input  logic        ex_upd_flag,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  rs1_addr,
  input  logic [2:0]  rs2_addr,
  output logic [15:0] rs1_data,
  output logic [15:0] rs2_data,
  output logic        zero_flag,
  output logic        lt_flag,
  output logic        wb_valid
);

  logic [15:0] regs_r [NUM_REGS];
  logic        wb_valid_r;
  logic [2:0]  wb_rd_r;
  logic [15:0] wb_data_r;
  logic        zero_flag_r;
  logic        lt_flag_r;
  logic        commit_s;
  logic        capture_s;

  // A pending write commits only on an unstalled, unflushed edge and never to R0.
  always_comb begin
    commit_s  = 1'b0;
    capture_s = 1'b0;
    if (!rst && !flush && !stall) begin
      capture_s = 1'b1;
      commit_s  = wb_valid_r && (wb_rd_r != 3'd0) && (32'(wb_rd_r) < NUM_REGS);
    end else begin
      capture_s = 1'b0;
      commit_s  = 1'b0;
    end
  end

  // Register file storage; reset clears every entry, including any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else if (commit_s) begin
      regs_r[wb_rd_r] <= wb_data_r;
    end else begin
      regs_r[wb_rd_r] <= regs_r[wb_rd_r];
    end
  end

  // Writeback pipe register and flags: reset beats flush, flush beats stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 3'd0;
      wb_data_r   <= 16'h0000;
      zero_flag_r <= 1'b0;
      lt_flag_r   <= 1'b0;
    end else if (flush) begin
      wb_valid_r  <= 1'b0;
    end else if (capture_s) begin
      wb_valid_r <= ex_valid & ex_reg_we;
      wb_rd_r    <= ex_rd;
      wb_data_r  <= alu_result;
      if (ex_valid && ex_upd_flag) begin
        zero_flag_r <= alu_zero;
        lt_flag_r   <= alu_lt;
      end
    end
  end

  // Read ports: R0 is hard-wired zero, then bypass from the pending write, then storage.
  always_comb begin
    rs1_data = 16'h0000;
    if (rs1_addr == 3'd0) begin
      rs1_data = 16'h0000;
    end else if (wb_valid_r && (wb_rd_r == rs1_addr)) begin
      rs1_data = wb_data_r;
    end else if (32'(rs1_addr) < NUM_REGS) begin
      rs1_data = regs_r[rs1_addr];
    end else begin
      rs1_data = 16'h0000;
    end
  end

  // Second read port, same priority as the first so equal addresses give equal data.
  always_comb begin
    rs2_data = 16'h0000;
    if (rs2_addr == 3'd0) begin
      rs2_data = 16'h0000;
    end else if (wb_valid_r && (wb_rd_r == rs2_addr)) begin
      rs2_data = wb_data_r;
    end else if (32'(rs2_addr) < NUM_REGS) begin
      rs2_data = regs_r[rs2_addr];
    end else begin
      rs2_data = 16'h0000;
    end
  end

  assign wb_valid  = wb_valid_r;
  assign zero_flag = zero_flag_r;
  assign lt_flag   = lt_flag_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: stimulus pushes the expected pre-edge
// outputs for each cycle into a queue; a negedge monitor pops and compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_we, ex_upd_flag;
  logic [2:0]  ex_rd;
  logic [15:0] alu_result;
  logic        alu_zero, alu_lt, stall, flush;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [15:0] rs1_data, rs2_data;
  logic        zero_flag, lt_flag, wb_valid;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic        zf;
    logic        lt;
    logic        wbv;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   stim_done = 1'b0;

  wb_regfile #(.NUM_REGS(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd),
    .ex_upd_flag(ex_upd_flag), .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .stall(stall), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .zero_flag(zero_flag), .lt_flag(lt_flag),
    .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input string field, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h (cycle %0d)", nm, field, act, exp, cycle);
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cycle) begin
        n_total++;
        $display("FAIL %s.missed: got cycle %0d expected cycle %0d", e.name, cycle, e.cyc);
      end else begin
        chk(e.name, "rs1_data", rs1_data, e.rs1);
        chk(e.name, "rs2_data", rs2_data, e.rs2);
        chk(e.name, "zero_flag", {15'd0, zero_flag}, {15'd0, e.zf});
        chk(e.name, "lt_flag", {15'd0, lt_flag}, {15'd0, e.lt});
        chk(e.name, "wb_valid", {15'd0, wb_valid}, {15'd0, e.wbv});
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic we, input logic [2:0] rd,
                      input logic upd, input logic [15:0] res, input logic z, input logic l,
                      input logic st, input logic fl, input logic [2:0] a1, input logic [2:0] a2);
    @(posedge clk);
    #2;
    rst = r; ex_valid = v; ex_reg_we = we; ex_rd = rd; ex_upd_flag = upd;
    alu_result = res; alu_zero = z; alu_lt = l; stall = st; flush = fl;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, a1, a2);
  endtask

  // Expected outputs seen before the coming edge, with the inputs just driven.
  task automatic exp_out(input string nm, input logic [15:0] e1, input logic [15:0] e2,
                         input logic ez, input logic el, input logic ev);
    exp_t e;
    e.cyc = cycle; e.name = nm; e.rs1 = e1; e.rs2 = e2; e.zf = ez; e.lt = el; e.wbv = ev;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_reg_we = 1'b0; ex_rd = 3'd0; ex_upd_flag = 1'b0;
    alu_result = 16'h0000; alu_zero = 1'b0; alu_lt = 1'b0; stall = 1'b0; flush = 1'b0;
    rs1_addr = 3'd3; rs2_addr = 3'd5;

    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd5);
    exp_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Write R3 then read via bypass and then via storage
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0);
    exp_out("wr3_pre", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle(3'd3, 3'd3);
    exp_out("wr3_bypass", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
    idle(3'd3, 3'd3);
    exp_out("wr3_stored", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Write to R0 is discarded
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3);
    exp_out("r0_pre", 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    idle(3'd0, 3'd0);
    exp_out("r0_pending", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(3'd0, 3'd3);
    exp_out("r0_after", 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Flags load only with ex_valid and ex_upd_flag
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0);
    exp_out("flag_pre", 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0);
    exp_out("flag_set", 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0);
    exp_out("flag_noupd", 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Write and flag update from the same instruction
    step(1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 3'd6);
    exp_out("both_pre", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle(3'd6, 3'd6);
    exp_out("both_post", 16'h0F0F, 16'h0F0F, 1'b1, 1'b0, 1'b1);

    // Stall holds a pending R5 write and blocks capture and flag update
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd6);
    exp_out("stall_pre", 16'h0000, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 3'd5);
      exp_out("stall_hold", 16'h00AA, 16'h00AA, 1'b1, 1'b0, 1'b1);
    end
    idle(3'd5, 3'd7);
    exp_out("stall_release", 16'h00AA, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle(3'd5, 3'd7);
    exp_out("stall_commit", 16'h00AA, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Flush with stall discards the pending R2 write and the new instruction
    step(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0BAD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd2);
    exp_out("flush_pre", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2);
    exp_out("flush_pending", 16'h0BAD, 16'h0BAD, 1'b1, 1'b0, 1'b1);
    idle(3'd4, 3'd2);
    exp_out("flush_after", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back R1 writes: first commits while the second is captured
    step(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
    exp_out("same_pre", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1);
    exp_out("same_first", 16'h5555, 16'h5555, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1);
    exp_out("same_second", 16'h6666, 16'h6666, 1'b0, 1'b1, 1'b1);
    idle(3'd1, 3'd1);
    exp_out("same_stored", 16'h5555, 16'h5555, 1'b0, 1'b1, 1'b0);

    // Reset with a pending write, stall and flush all asserted
    step(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd5);
    exp_out("rst_pre", 16'h5555, 16'h00AA, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 3'd5);
    exp_out("rst_pending", 16'h6666, 16'h00AA, 1'b0, 1'b1, 1'b1);
    idle(3'd1, 3'd5);
    exp_out("rst_after", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle(3'd3, 3'd6);
    exp_out("rst_all", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    idle(3'd0, 3'd0);
    idle(3'd0, 3'd0);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    if (!stim_done) begin
      $display("FAIL timeout: got cycle %0d expected completion", cycle);
      $fatal(1, "timeout");
    end
  end

endmodule
